dmem_wbuf: RTL and testbench

DMEM_WBUF -- requirements
Module: dmem_wbuf

---
 rtl/dmem_wbuf_pkg.sv | 25 ++
 rtl/dmem_wbuf_fifo.sv | 78 +++++++
 rtl/dmem_wbuf.sv | 178 +++++++++++++++++
 tb/tb_dmem_wbuf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_wbuf_pkg.sv
// Shared types and constants for the data-memory write buffer.
package dmem_wbuf_pkg;

    // Default number of store-buffer entries.
    localparam int WBUF_DEPTH_DEFAULT = 4;

    // One buffered store: word address, store data and byte enables.
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    // Drain state machine encoding.
    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_BUSY = 1'b1
    } drain_state_t;

    // Word address of a byte address.
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// Store-buffer storage: circular array with head/tail pointers and an
// occupancy count. Exposes the full array and the head pointer so the
// parent can search every valid entry for load hazards.
module wbuf_fifo
    import dmem_wbuf_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  wbuf_entry_t               push_entry,
    input  logic                      pop,
    output logic [PTR_W-1:0]          head_ptr,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty,
    output wbuf_entry_t [DEPTH-1:0]   entries
);

    wbuf_entry_t [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0]        head_r;
    logic [PTR_W-1:0]        tail_r;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_next_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // Entry storage, written at the tail; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[tail_r] <= push_entry;
        end
    end

    assign head_ptr = head_r;
    assign count    = count_r;
    assign full     = full_s;
    assign empty    = empty_s;
    assign entries  = mem_r;

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory write buffer: queues CPU stores and drains them to memory
// one at a time, while loads read memory directly unless they hit a
// buffered store. Optional feature macro: WBUF_FWD_EN -- forward the
// youngest matching full-word store to a load instead of stalling.
module dmem_wbuf
    import dmem_wbuf_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    input  logic        drd,
    output logic [31:0] drdata,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    drain_state_t            state_r;
    drain_state_t            state_next_s;
    logic                    store_s;
    logic                    load_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    empty_s;
    logic [CNT_W-1:0]        count_s;
    logic [PTR_W-1:0]        head_ptr_s;
    wbuf_entry_t [DEPTH-1:0] entries_s;
    wbuf_entry_t             head_entry_s;
    wbuf_entry_t             push_entry_s;
    logic                    match_any_s;
    logic                    hazard_s;
    logic                    stall_store_s;
    logic                    stall_load_s;
    logic                    daddr_lsb_unused_s;
`ifdef WBUF_FWD_EN
    logic [3:0]              yng_be_s;
    logic [31:0]             yng_data_s;
    logic                    fwd_ok_s;
`endif

    // A store owns the cycle; a simultaneous load request is ignored.
    assign store_s       = (dwe != 4'b0000);
    assign load_s        = drd & ~store_s;
    assign stall_store_s = store_s & full_s;
    assign push_s        = store_s & ~full_s;
    assign pop_s         = (state_r == DRAIN_BUSY) & mem_ack;

    assign push_entry_s.waddr = word_addr(daddr);
    assign push_entry_s.data  = dwdata;
    assign push_entry_s.be    = dwe;

    assign daddr_lsb_unused_s = ^daddr[1:0];

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head_ptr   (head_ptr_s),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s),
        .entries    (entries_s)
    );

    // Search valid entries oldest to youngest; the last hit is the youngest.
    // The head entry counts even while it pops this cycle.
    always_comb begin
        logic [PTR_W-1:0] slot_v;
        logic             hit_v;
        match_any_s = 1'b0;
`ifdef WBUF_FWD_EN
        yng_be_s    = 4'b0000;
        yng_data_s  = 32'h0000_0000;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            slot_v      = head_ptr_s + PTR_W'(k);
            hit_v       = (CNT_W'(k) < count_s) &&
                          (entries_s[slot_v].waddr == word_addr(daddr));
            match_any_s = match_any_s | hit_v;
`ifdef WBUF_FWD_EN
            yng_be_s    = hit_v ? entries_s[slot_v].be   : yng_be_s;
            yng_data_s  = hit_v ? entries_s[slot_v].data : yng_data_s;
`endif
        end
    end

    assign hazard_s = load_s & match_any_s;

`ifdef WBUF_FWD_EN
    assign fwd_ok_s     = (yng_be_s == 4'b1111);
    assign stall_load_s = hazard_s & ~fwd_ok_s;
`else
    assign stall_load_s = hazard_s;
`endif

    // CPU-facing stall and load data; both forced low while in reset.
    always_comb begin
        stall  = 1'b0;
        drdata = 32'h0000_0000;
        if (reset) begin
            stall  = 1'b0;
            drdata = 32'h0000_0000;
        end else begin
            stall = stall_store_s | stall_load_s;
            if (load_s) begin
`ifdef WBUF_FWD_EN
                if (hazard_s && fwd_ok_s) begin
                    drdata = yng_data_s;
                end else begin
                    drdata = mem_rdata;
                end
`else
                drdata = mem_rdata;
`endif
            end else begin
                drdata = 32'h0000_0000;
            end
        end
    end

    // Drain state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= DRAIN_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Drain next state: leave BUSY only when the last entry is acked and
    // nothing new arrives; a store into an empty buffer starts draining next cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DRAIN_IDLE: begin
                if (!empty_s || push_s) begin
                    state_next_s = DRAIN_BUSY;
                end else begin
                    state_next_s = DRAIN_IDLE;
                end
            end
            DRAIN_BUSY: begin
                if (mem_ack && (count_s == CNT_W'(1'b1)) && !push_s) begin
                    state_next_s = DRAIN_IDLE;
                end else begin
                    state_next_s = DRAIN_BUSY;
                end
            end
            default: state_next_s = DRAIN_IDLE;
        endcase
    end

    // Head entry is held in storage, so the request stays stable until acked.
    assign head_entry_s = entries_s[head_ptr_s];
    assign mem_req      = (state_r == DRAIN_BUSY) & ~reset;
    assign mem_addr     = {head_entry_s.waddr, 2'b00};
    assign mem_wdata    = head_entry_s.data;
    assign mem_be       = head_entry_s.be;
    assign mem_raddr    = {daddr[31:2], 2'b00};

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: a per-cycle vector table plus hand-written
// sequences for same-cycle push/pop and reset during an active drain.
module tb_dmem_wbuf;

`ifdef WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic        drd;
    logic [31:0] drdata;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_wbuf #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dwe       (dwe),
        .drd       (drd),
        .drdata    (drdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwe;
        logic        drd;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_drdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                                input logic rd, input logic ack, input logic [31:0] rdat,
                                input logic es, input logic er, input logic [31:0] ea,
                                input logic [31:0] ew, input logic [3:0] eb, input logic [31:0] ed);
        vec_t v;
        v.daddr = a; v.dwdata = d; v.dwe = we; v.drd = rd; v.ack = ack; v.rdata = rdat;
        v.exp_stall = es; v.exp_req = er; v.exp_addr = ea; v.exp_wdata = ew;
        v.exp_be = eb; v.exp_drdata = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                         input logic rd, input logic ack, input logic [31:0] rdat);
        daddr = a; dwdata = d; dwe = we; drd = rd; mem_ack = ack; mem_rdata = rdat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // store-then-ack (0x100)
        vecs.push_back(mk(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        // fill to full, fifth store stalls (also while an ack pops), then drain in order
        vecs.push_back(mk(32'h0,  32'hA0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(32'h4,  32'hA4, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'hA0, 4'hF, 32'h0));
        vecs.push_back(mk(32'h8,  32'hA8, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'hA0, 4'hF, 32'h0));
        vecs.push_back(mk(32'hC,  32'hAC, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'hA0, 4'hF, 32'h0));
        vecs.push_back(mk(32'h10, 32'hB0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'hA0, 4'hF, 32'h0));
        vecs.push_back(mk(32'h10, 32'hB0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'hA0, 4'hF, 32'h0));
        vecs.push_back(mk(32'h10, 32'hB0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'hA4, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h4,  32'hA4, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h8,  32'hA8, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hC,  32'hAC, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10, 32'hB0, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        // byte store to 0x203, load of 0x200 stalls until its ack (popping entry still matches)
        vecs.push_back(mk(32'h203, 32'h77777777, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(32'h200, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'h200, 32'h77777777, 4'b1000, 32'h12345678));
        vecs.push_back(mk(32'h200, 32'h0, 4'h0, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h200, 32'h77777777, 4'b1000, 32'h12345678));
        vecs.push_back(mk(32'h200, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678));
        // full-word store to 0x40 (with drd also high: store wins, drdata 0), then loads
        vecs.push_back(mk(32'h40, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(32'h44, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'hCAFEF00D));
        vecs.push_back(mk(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'h99999999, !FWD, 1'b1, 32'h40, 32'h11223344, 4'hF,
                          FWD ? 32'h11223344 : 32'h99999999));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        // youngest-match rule: partial youngest stalls, full youngest forwards
        vecs.push_back(mk(32'h80, 32'h1, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(32'h80, 32'h2, 4'b0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h1, 4'hF, 32'h0));
        vecs.push_back(mk(32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 32'h5, 1'b1, 1'b1, 32'h80, 32'h1, 4'hF, 32'h5));
        vecs.push_back(mk(32'h80, 32'h3, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h1, 4'hF, 32'h0));
        vecs.push_back(mk(32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 32'h5, !FWD, 1'b1, 32'h80, 32'h1, 4'hF, FWD ? 32'h3 : 32'h5));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 32'h1, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 32'h2, 4'b0001, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 32'h3, 4'hF, 32'h0));
        vecs.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));

        // Reset state: outputs low even with a load pending
        reset = 1'b1;
        drive(32'h600, 32'h0, 4'h0, 1'b1, 1'b1, 32'h55AA55AA);
        next_cycle();
        chk("rst mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst stall",   {31'h0, stall},   32'h0);
        chk("rst drdata",  drdata,           32'h0);
        reset = 1'b0;
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("post-rst mem_req", {31'h0, mem_req}, 32'h0);
        next_cycle();

        // Table-driven vectors, one per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].daddr, vecs[i].dwdata, vecs[i].dwe, vecs[i].drd, vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d stall", i),   {31'h0, stall},   {31'h0, vecs[i].exp_stall});
            chk($sformatf("v%0d mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].exp_req});
            chk($sformatf("v%0d drdata", i),  drdata,           vecs[i].exp_drdata);
            chk($sformatf("v%0d mem_raddr", i), mem_raddr, vecs[i].daddr & 32'hFFFF_FFFC);
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].exp_addr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d mem_be", i),    {28'h0, mem_be}, {28'h0, vecs[i].exp_be});
            end
            next_cycle();
        end

        // Push and ack in the same cycle with two entries queued
        drive(32'h500, 32'h50, 4'hF, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h504, 32'h54, 4'hF, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h508, 32'h58, 4'hF, 1'b0, 1'b1, 32'h0);
        #1;
        chk("pp count before", {29'h0, dut.u_fifo.count_r}, 32'd2);
        chk("pp addr before",  mem_addr, 32'h500);
        chk("pp stall",        {31'h0, stall}, 32'h0);
        next_cycle();
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("pp count after", {29'h0, dut.u_fifo.count_r}, 32'd2);
        chk("pp head addr",   mem_addr,  32'h504);
        chk("pp head data",   mem_wdata, 32'h54);
        mem_ack = 1'b1;
        next_cycle();
        chk("pp tail addr", mem_addr,  32'h508);
        chk("pp tail data", mem_wdata, 32'h58);
        next_cycle();
        mem_ack = 1'b0;
        #1;
        chk("pp drained req", {31'h0, mem_req}, 32'h0);

        // Reset in the middle of a drain with three entries pending
        drive(32'h600, 32'h60, 4'hF, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h604, 32'h64, 4'hF, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h608, 32'h68, 4'b0011, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h608, 32'h0, 4'h0, 1'b1, 1'b0, 32'h33333333);
        #1;
        chk("mid req before",   {31'h0, mem_req}, 32'h1);
        chk("mid count before", {29'h0, dut.u_fifo.count_r}, 32'd3);
        chk("mid stall before", {31'h0, stall}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid rst mem_req", {31'h0, mem_req}, 32'h0);
        chk("mid rst stall",   {31'h0, stall},   32'h0);
        chk("mid rst drdata",  drdata,           32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("after rst req c%0d", c), {31'h0, mem_req}, 32'h0);
            next_cycle();
        end
        chk("after rst count", {29'h0, dut.u_fifo.count_r}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
